alu_sequencer: RTL and testbench

//  Byte-stream controller that sequences the 8-bit ALU: accepts operand A, operand B and opcode as

---
 rtl/alu_sequencer.sv | 171 +++++++++++++++++
 tb/tb_alu_sequencer.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_sequencer.sv
// -----------------------------------------------------------------------------
// alu_sequencer
//   Serial command front-end for the 8-bit ALU. Three consecutive received
//   bytes (operand A, operand B, opcode) are latched onto the ALU inputs. One
//   cycle is then allowed for the ALU to settle, and the result is handed to
//   the byte transmitter. A partial command that stalls is abandoned after
//   TIMEOUT_CYCLES idle cycles. Bytes that arrive while a result is being
//   produced or sent are dropped and flagged.
//
// Ports
//   clk          system clock, all logic on posedge
//   rst          synchronous, active-high reset
//   rx_data      received byte, valid while rx_valid=1
//   rx_valid     one-cycle strobe for a new received byte
//   tx_data      result byte, stable from tx_start until tx_done
//   tx_start     one-cycle request to transmit tx_data
//   tx_done      one-cycle strobe: transmitter finished the byte
//   alu_a/alu_b  ALU operands
//   alu_opcode   ALU opcode (low OP_LEN bits of the opcode byte)
//   alu_result   combinational ALU output
//   busy         high whenever the sequencer is not idle waiting for byte A
//   timeout_err  one-cycle pulse when a partial command is abandoned
//   rx_overrun   sticky flag: byte arrived outside a receive state
// -----------------------------------------------------------------------------
module alu_sequencer #(
  parameter int BUS_LEN        = 8,
  parameter int OP_LEN         = 6,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [BUS_LEN-1:0] rx_data,
  input  logic               rx_valid,
  output logic [BUS_LEN-1:0] tx_data,
  output logic               tx_start,
  input  logic               tx_done,
  output logic [BUS_LEN-1:0] alu_a,
  output logic [BUS_LEN-1:0] alu_b,
  output logic [OP_LEN-1:0]  alu_opcode,
  input  logic [BUS_LEN-1:0] alu_result,
  output logic               busy,
  output logic               timeout_err,
  output logic               rx_overrun
);

  // A zero TIMEOUT_CYCLES disables the timeout; keep the counter one bit wide
  // in that case so the declaration stays legal.
  localparam bit TIMEOUT_EN = (TIMEOUT_CYCLES > 0);
  localparam int CNT_W      = TIMEOUT_EN ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST =
    TIMEOUT_EN ? CNT_W'(TIMEOUT_CYCLES - 1) : '0;

  typedef enum logic [2:0] {
    RX_A, RX_B, RX_OP, EXEC, TX, TX_WAIT
  } state_e;

  state_e             state_q,       state_d;
  logic [BUS_LEN-1:0] alu_a_q,       alu_a_d;
  logic [BUS_LEN-1:0] alu_b_q,       alu_b_d;
  logic [OP_LEN-1:0]  alu_opcode_q,  alu_opcode_d;
  logic [BUS_LEN-1:0] tx_data_q,     tx_data_d;
  logic               tx_start_q,    tx_start_d;
  logic               busy_q,        busy_d;
  logic               timeout_err_q, timeout_err_d;
  logic               rx_overrun_q,  rx_overrun_d;
  logic [CNT_W-1:0]   cnt_q,         cnt_d;

  logic waiting_mid_cmd;

  assign waiting_mid_cmd = TIMEOUT_EN && !rx_valid &&
                           (state_q == RX_B || state_q == RX_OP);

  always_comb begin
    // NOTE: every signal written here gets a default first; a path that
    // leaves one unassigned would infer a latch.
    state_d       = state_q;
    alu_a_d       = alu_a_q;
    alu_b_d       = alu_b_q;
    alu_opcode_d  = alu_opcode_q;
    tx_data_d     = tx_data_q;
    tx_start_d    = 1'b0;
    timeout_err_d = 1'b0;
    rx_overrun_d  = rx_overrun_q;
    cnt_d         = cnt_q;

    unique case (state_q)
      RX_A: if (rx_valid) begin
        alu_a_d = rx_data;
        cnt_d   = '0;
        state_d = RX_B;
      end
      RX_B: if (rx_valid) begin
        alu_b_d = rx_data;
        cnt_d   = '0;
        state_d = RX_OP;
      end
      RX_OP: if (rx_valid) begin
        alu_opcode_d = rx_data[OP_LEN-1:0];
        cnt_d        = '0;
        state_d      = EXEC;
      end
      // The ALU inputs were updated on the previous edge; its result has
      // settled by now.
      EXEC: begin
        tx_data_d  = alu_result;
        tx_start_d = 1'b1;
        state_d    = TX;
      end
      // A transmitter that finishes during the start cycle is honoured here
      // rather than being lost.
      TX:      state_d = tx_done ? RX_A : TX_WAIT;
      TX_WAIT: if (tx_done) state_d = RX_A;
      default: state_d = RX_A;
    endcase

    // Idle-cycle watchdog for a partially received command. An rx_valid in
    // the final cycle takes the accept path above instead.
    if (waiting_mid_cmd) begin
      if (cnt_q == CNT_LAST) begin
        timeout_err_d = 1'b1;
        cnt_d         = '0;
        state_d       = RX_A;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end

    if (rx_valid && (state_q == EXEC || state_q == TX || state_q == TX_WAIT))
      rx_overrun_d = 1'b1;

    busy_d = (state_d != RX_A);
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples its _d value from before this edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= RX_A;
      alu_a_q       <= '0;
      alu_b_q       <= '0;
      alu_opcode_q  <= '0;
      tx_data_q     <= '0;
      tx_start_q    <= 1'b0;
      busy_q        <= 1'b0;
      timeout_err_q <= 1'b0;
      rx_overrun_q  <= 1'b0;
      cnt_q         <= '0;
    end else begin
      state_q       <= state_d;
      alu_a_q       <= alu_a_d;
      alu_b_q       <= alu_b_d;
      alu_opcode_q  <= alu_opcode_d;
      tx_data_q     <= tx_data_d;
      tx_start_q    <= tx_start_d;
      busy_q        <= busy_d;
      timeout_err_q <= timeout_err_d;
      rx_overrun_q  <= rx_overrun_d;
      cnt_q         <= cnt_d;
    end
  end

  assign alu_a       = alu_a_q;
  assign alu_b       = alu_b_q;
  assign alu_opcode  = alu_opcode_q;
  assign tx_data     = tx_data_q;
  assign tx_start    = tx_start_q;
  assign busy        = busy_q;
  assign timeout_err = timeout_err_q;
  assign rx_overrun  = rx_overrun_q;

endmodule

// File: tb/tb_alu_sequencer.sv
// -----------------------------------------------------------------------------
// tb_alu_sequencer
//   Directed bench for alu_sequencer with a small ALU stand-in. A transaction
//   model (bytes collected so far, transmit phase, idle count) predicts every
//   output; it is compared at each falling edge. Literal expectations pin
//   the model to hand-computed values.
// -----------------------------------------------------------------------------
module tb_alu_sequencer;

  localparam int BUS_LEN = 8;
  localparam int OP_LEN  = 6;
  localparam int TO      = 16;

  logic               clk = 1'b0;
  logic               rst;
  logic [BUS_LEN-1:0] rx_data;
  logic               rx_valid;
  logic [BUS_LEN-1:0] tx_data;
  logic               tx_start;
  logic               tx_done;
  logic [BUS_LEN-1:0] alu_a, alu_b, alu_result;
  logic [OP_LEN-1:0]  alu_opcode;
  logic               busy, timeout_err, rx_overrun;

  int tests  = 0;
  int fails  = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  alu_sequencer #(
    .BUS_LEN(BUS_LEN), .OP_LEN(OP_LEN), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk), .rst(rst),
    .rx_data(rx_data), .rx_valid(rx_valid),
    .tx_data(tx_data), .tx_start(tx_start), .tx_done(tx_done),
    .alu_a(alu_a), .alu_b(alu_b), .alu_opcode(alu_opcode),
    .alu_result(alu_result),
    .busy(busy), .timeout_err(timeout_err), .rx_overrun(rx_overrun)
  );

  // ALU stand-in: ADD, SUB, AND, OR, XOR, anything else yields zero.
  function automatic logic [7:0] alu_f(logic [7:0] a, logic [7:0] b, logic [5:0] op);
    case (op)
      6'h20:   return a + b;
      6'h22:   return a - b;
      6'h24:   return a & b;
      6'h25:   return a | b;
      6'h26:   return a ^ b;
      default: return 8'h00;
    endcase
  endfunction

  assign alu_result = alu_f(alu_a, alu_b, alu_opcode);

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Transaction model. m_phase: 0 collecting bytes, 1 result pending,
  // 2 start cycle, 3 waiting for the transmitter.
  // ---------------------------------------------------------------------------
  logic [7:0] m_a, m_b, m_tx;
  logic [5:0] m_op;
  logic       m_start, m_to, m_ovr;
  int         m_ncol, m_idle, m_phase;
  logic       m_busy;

  assign m_busy = !(m_phase == 0 && m_ncol == 0);

  always @(posedge clk) begin
    if (rst) begin
      m_a <= '0; m_b <= '0; m_op <= '0; m_tx <= '0;
      m_start <= 1'b0; m_to <= 1'b0; m_ovr <= 1'b0;
      m_ncol <= 0; m_idle <= 0; m_phase <= 0;
    end else begin
      m_start <= 1'b0;
      m_to    <= 1'b0;
      if (m_phase == 0) begin
        if (rx_valid) begin
          if (m_ncol == 0)      m_a  <= rx_data;
          else if (m_ncol == 1) m_b  <= rx_data;
          else                  m_op <= rx_data[5:0];
          m_idle <= 0;
          if (m_ncol == 2) begin m_ncol <= 0; m_phase <= 1; end
          else m_ncol <= m_ncol + 1;
        end else if (m_ncol > 0) begin
          if (m_idle == TO - 1) begin m_to <= 1'b1; m_ncol <= 0; m_idle <= 0; end
          else m_idle <= m_idle + 1;
        end
      end else begin
        if (rx_valid) m_ovr <= 1'b1;
        if (m_phase == 1) begin
          m_tx    <= alu_f(m_a, m_b, m_op);
          m_start <= 1'b1;
          m_phase <= 2;
        end else if (tx_done) m_phase <= 0;
        else                  m_phase <= 3;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en)
      check("cycle_outputs",
            {30'd0, tx_data, tx_start, alu_a, alu_b, alu_opcode, busy, timeout_err, rx_overrun},
            {30'd0, m_tx, m_start, m_a, m_b, m_op, m_busy, m_to, m_ovr});
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers; inputs change on the falling edge.
  // ---------------------------------------------------------------------------
  task automatic send_byte(logic [7:0] b);
    @(negedge clk);
    rx_valid = 1'b1;
    rx_data  = b;
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic send_cmd(logic [7:0] a, logic [7:0] b, logic [7:0] op);
    send_byte(a);
    send_byte(b);
    send_byte(op);
  endtask

  // Returns the number of falling edges until tx_start is seen (0 = never).
  task automatic wait_tx(output int n);
    n = 0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (tx_start) begin n = i; break; end
    end
    if (n == 0) check("tx_start_seen", 64'd0, 64'd1);
  endtask

  task automatic done_pulse();
    @(negedge clk);
    tx_done = 1'b1;
    @(negedge clk);
    tx_done = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    rst = 1'b1; rx_valid = 1'b0; rx_data = '0; tx_done = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst    = 1'b0;
    chk_en = 1'b1;
    check("reset_outputs",
          {tx_data, tx_start, alu_a, alu_b, alu_opcode, busy, timeout_err, rx_overrun},
          '0);

    // 1: ADD, result two cycles after the opcode byte.
    send_cmd(8'h05, 8'h03, 8'h20);
    wait_tx(n);
    check("t1_latency", 64'(n), 64'd1);
    check("t1_tx_data", tx_data, 8'h08);
    check("t1_operands", {alu_a, alu_b, 2'b00, alu_opcode}, {8'h05, 8'h03, 8'h20});
    @(negedge clk);
    check("t1_start_one_cycle", tx_start, 1'b0);
    check("t1_busy_wait", busy, 1'b1);
    done_pulse();
    check("t1_idle", busy, 1'b0);

    // 2: SUB with opcode upper bits dropped; tx_done lands in the start cycle.
    send_cmd(8'h03, 8'h05, 8'hE2);
    wait_tx(n);
    check("t2_opcode", alu_opcode, 6'h22);
    check("t2_tx_data", tx_data, 8'hFE);
    tx_done = 1'b1;
    @(negedge clk);
    tx_done = 1'b0;
    check("t2_done_in_tx", busy, 1'b0);
    done_pulse();   // stray tx_done while idle must be ignored
    check("t2_stray_done", busy, 1'b0);

    // 3: abandoned command times out 16 cycles after the byte.
    send_byte(8'hAA);
    n = 0;
    do begin @(negedge clk); n++; end while (!timeout_err && n < 40);
    check("t3_timeout_latency", 64'(n), 64'd16);
    check("t3_after_timeout", {busy, alu_a}, {1'b0, 8'hAA});
    @(negedge clk);
    check("t3_pulse_width", timeout_err, 1'b0);
    send_cmd(8'h07, 8'h02, 8'h22);
    wait_tx(n);
    check("t3_fresh_result", tx_data, 8'h05);
    done_pulse();

    // 4: byte in exactly the timeout cycle is accepted.
    send_byte(8'h11);
    repeat (15) @(negedge clk);
    rx_valid = 1'b1;
    rx_data  = 8'h22;
    @(negedge clk);
    rx_valid = 1'b0;
    check("t4_no_timeout", timeout_err, 1'b0);
    check("t4_b_taken", {busy, alu_b}, {1'b1, 8'h22});
    send_byte(8'h20);
    wait_tx(n);
    check("t4_result", tx_data, 8'h33);
    done_pulse();

    // 5: byte during TX_WAIT sets sticky overrun, result unaffected.
    send_cmd(8'h01, 8'h01, 8'h20);
    wait_tx(n);
    repeat (2) @(negedge clk);
    send_byte(8'h99);
    check("t5_overrun", rx_overrun, 1'b1);
    check("t5_unchanged", {tx_data, alu_a, busy}, {8'h02, 8'h01, 1'b1});
    done_pulse();
    send_cmd(8'h02, 8'h03, 8'h20);
    wait_tx(n);
    check("t5_next_result", tx_data, 8'h05);
    done_pulse();
    check("t5_sticky", rx_overrun, 1'b1);

    // 6: reset while in EXEC aborts without transmit.
    send_cmd(8'h04, 8'h04, 8'h20);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("t6_reset_outputs",
          {tx_data, tx_start, alu_a, alu_b, alu_opcode, busy, timeout_err, rx_overrun},
          '0);
    repeat (3) @(negedge clk);
    send_cmd(8'h09, 8'h01, 8'h20);
    wait_tx(n);
    check("t6_clean_result", tx_data, 8'h0A);
    done_pulse();

    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
